// File: rtl/garduino_pwm_outputs.sv
// Avalon-MM output-port controller: NUM_CH lines, each either a static level
// or a PWM output with period-aligned, double-buffered duty updates.

module garduino_pwm_outputs_ch #(
    parameter int   PWM_BITS = 8,
    parameter logic RST_LVL  = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                shadow_we_i,
    input  logic [PWM_BITS-1:0] wdata_i,
    input  logic                load_i,
    input  logic                mode_i,
    input  logic                data_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic [PWM_BITS-1:0] shadow_o,
    output logic                out_o
);
    logic [PWM_BITS-1:0] shadow_q, active_q;
    logic                out_q;

    // On a load coinciding with a shadow write, the old shadow goes active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
            out_q    <= RST_LVL;
        end else begin
            if (shadow_we_i) shadow_q <= wdata_i;
            if (load_i)      active_q <= shadow_q;
            out_q <= mode_i ? (pwm_cnt_i < active_q) : data_i;
        end
    end

    assign shadow_o = shadow_q;
    assign out_o    = out_q;
endmodule

module garduino_pwm_outputs #(
    parameter int                NUM_CH        = 8,
    parameter int                PWM_BITS      = 8,
    parameter int                PRESCALE_BITS = 16,
    parameter logic [NUM_CH-1:0] RESET_VALUE   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] out_port
);
    logic                         wr;
    logic                         presc_wr, tick, duty_load;
    logic [NUM_CH-1:0]            data_q, data_d;
    logic [NUM_CH-1:0]            mode_q, mode_d;
    logic [PRESCALE_BITS-1:0]     presc_q, presc_d;
    logic [PRESCALE_BITS-1:0]     pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
    logic [NUM_CH-1:0][PWM_BITS-1:0] duty_shadow;
    logic [NUM_CH-1:0]            out_w;
    logic                         unused_wd;

    assign wr        = chipselect & ~write_n;
    assign presc_wr  = wr && (address == 4'd4);
    assign tick      = (pre_cnt_q == presc_q);
    assign duty_load = presc_wr | (tick & (&pwm_cnt_q));
    assign unused_wd = ^writedata;

    always_comb begin
        data_d  = data_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        if (wr) begin
            case (address)
                4'd0: data_d  = writedata[NUM_CH-1:0];
                4'd1: data_d  = data_q | writedata[NUM_CH-1:0];
                4'd2: data_d  = data_q & ~writedata[NUM_CH-1:0];
                4'd3: mode_d  = writedata[NUM_CH-1:0];
                4'd4: presc_d = writedata[PRESCALE_BITS-1:0];
                default: ;
            endcase
        end
    end

    // A PRESCALE write restarts the PWM phase and wins over any tick.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PRESCALE_BITS'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (presc_wr) begin
            pre_cnt_d = '0;
            pwm_cnt_d = '0;
        end else if (tick) begin
            pre_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= RESET_VALUE;
            mode_q    <= '0;
            presc_q   <= '0;
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            data_q    <= data_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        garduino_pwm_outputs_ch #(
            .PWM_BITS (PWM_BITS),
            .RST_LVL  (RESET_VALUE[c])
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .shadow_we_i (wr && (address == 4'(8 + c))),
            .wdata_i     (writedata[PWM_BITS-1:0]),
            .load_i      (duty_load),
            .mode_i      (mode_q[c]),
            .data_i      (data_q[c]),
            .pwm_cnt_i   (pwm_cnt_q),
            .shadow_o    (duty_shadow[c]),
            .out_o       (out_w[c])
        );
    end

    assign out_port = out_w;

    always_comb begin
        readdata = '0;
        case (address)
            4'd0, 4'd1, 4'd2: readdata = 32'(data_q);
            4'd3:             readdata = 32'(mode_q);
            4'd4:             readdata = 32'(presc_q);
            4'd5:             readdata = 32'(out_w);
            4'd6:             readdata = 32'(pwm_cnt_q);
            default: begin
                for (int c = 0; c < NUM_CH; c++)
                    if (address == 4'(8 + c)) readdata = 32'(duty_shadow[c]);
            end
        endcase
    end
endmodule

// File: tb/tb_garduino_pwm_outputs.sv
// Directed bench for garduino_pwm_outputs: an 8-channel instance for the main
// features and a 6-channel instance for unmapped-channel behaviour.

module tb_garduino_pwm_outputs;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        cs, cs2, write_n;
    logic [31:0] writedata;
    logic [31:0] readdata, readdata2;
    logic [7:0]  out_port;
    logic [5:0]  out2;

    int nchk = 0;
    int nerr = 0;
    int hi_cnt [4];

    always #5 clk = ~clk;

    garduino_pwm_outputs #(
        .NUM_CH(8), .PWM_BITS(8), .PRESCALE_BITS(16), .RESET_VALUE(8'hA5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port)
    );

    garduino_pwm_outputs #(
        .NUM_CH(6), .PWM_BITS(8), .PRESCALE_BITS(16), .RESET_VALUE(6'h15)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
        .write_n(write_n), .writedata(writedata), .readdata(readdata2),
        .out_port(out2)
    );

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        cs = 1'b0; write_n = 1'b1;
    endtask

    task automatic wr2(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs2 = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        cs2 = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a; #1; d = readdata;
    endtask

    task automatic rd2(input logic [3:0] a, output logic [31:0] d);
        address = a; #1; d = readdata2;
    endtask

    // Runs nper 256-cycle windows counting ch0 high samples; optional duty0
    // write sampled on edge number wr_at after the call.
    task automatic pwm_run(input int nper, input int wr_at, input logic [31:0] wv);
        for (int p = 0; p < 4; p++) hi_cnt[p] = 0;
        for (int i = 1; i <= nper * 256; i++) begin
            @(negedge clk);
            if (i == wr_at) begin
                cs = 1'b1; write_n = 1'b0; address = 4'd8; writedata = wv;
            end
            @(posedge clk); #1;
            cs = 1'b0; write_n = 1'b1;
            hi_cnt[(i - 1) / 256] += int'(out_port[0]);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #12;
        nchk++; if (out_port !== 8'hA5) begin nerr++; $display("FAIL rst_out got %h exp a5", out_port); end
        nchk++; if (out2 !== 6'h15) begin nerr++; $display("FAIL rst_out2 got %h exp 15", out2); end
        rd(4'd3, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL rst_mode got %h exp 0", v); end
        rd(4'd4, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL rst_presc got %h exp 0", v); end
        rd(4'd8, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL rst_duty0 got %h exp 0", v); end
        @(negedge clk); reset_n = 1'b1;
        wr(4'd0, 32'h3C);
        nchk++; if (out_port !== 8'hA5) begin nerr++; $display("FAIL data_lat got %h exp a5", out_port); end
        @(posedge clk); #1;
        nchk++; if (out_port !== 8'h3C) begin nerr++; $display("FAIL data_out got %h exp 3c", out_port); end
        rd(4'd5, v); nchk++; if (v !== 32'h3C) begin nerr++; $display("FAIL level got %h exp 3c", v); end
    endtask

    task automatic test_set_clr();
        logic [31:0] v;
        wr(4'd0, 32'h0F);
        wr(4'd1, 32'hFFFF_FFF0);
        rd(4'd0, v); nchk++; if (v !== 32'hFF) begin nerr++; $display("FAIL outset got %h exp ff", v); end
        rd(4'd1, v); nchk++; if (v !== 32'hFF) begin nerr++; $display("FAIL rd_outset got %h exp ff", v); end
        wr(4'd2, 32'h81);
        rd(4'd2, v); nchk++; if (v !== 32'h7E) begin nerr++; $display("FAIL outclr got %h exp 7e", v); end
        rd(4'd0, v); nchk++; if (v !== 32'h7E) begin nerr++; $display("FAIL rd_data got %h exp 7e", v); end
        @(posedge clk); #1;
        nchk++; if (out_port !== 8'h7E) begin nerr++; $display("FAIL setclr_out got %h exp 7e", out_port); end
    endtask

    task automatic test_pwm_basic();
        logic [31:0] v;
        wr(4'd8, 32'd64);
        wr(4'd3, 32'h01);
        wr(4'd0, 32'h7E);
        wr(4'd4, 32'd0);
        rd(4'd6, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL pwmcnt_sync got %h exp 0", v); end
        pwm_run(2, 0, 32'd0);
        nchk++; if (hi_cnt[0] != 64) begin nerr++; $display("FAIL duty64_p0 got %0d exp 64", hi_cnt[0]); end
        nchk++; if (hi_cnt[1] != 64) begin nerr++; $display("FAIL duty64_p1 got %0d exp 64", hi_cnt[1]); end
        nchk++; if (out_port[7:1] !== 7'h3F) begin nerr++; $display("FAIL static_ch got %h exp 3f", out_port[7:1]); end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        int hi;
        hi = 0;
        wr(4'd8, 32'd128);
        wr(4'd4, 32'd3);
        rd(4'd4, v); nchk++; if (v !== 32'd3) begin nerr++; $display("FAIL presc_rd got %h exp 3", v); end
        for (int i = 1; i <= 1024; i++) begin
            @(posedge clk); #1;
            hi += int'(out_port[0]);
            if (i == 8) begin
                rd(4'd6, v); nchk++;
                if (v !== 32'd2) begin nerr++; $display("FAIL pwmcnt_div4 got %h exp 2", v); end
            end
        end
        nchk++; if (hi != 512) begin nerr++; $display("FAIL duty128_div4 got %0d exp 512", hi); end
        rd(4'd6, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL pwmcnt_wrap got %h exp 0", v); end
    endtask

    task automatic test_glitch_free();
        logic [31:0] v;
        wr(4'd8, 32'd64);
        wr(4'd4, 32'd0);
        pwm_run(2, 101, 32'd200);
        nchk++; if (hi_cnt[0] != 64) begin nerr++; $display("FAIL midper_old got %0d exp 64", hi_cnt[0]); end
        nchk++; if (hi_cnt[1] != 200) begin nerr++; $display("FAIL midper_new got %0d exp 200", hi_cnt[1]); end
        rd(4'd8, v); nchk++; if (v !== 32'd200) begin nerr++; $display("FAIL shadow_rd got %h exp c8", v); end
        wr(4'd8, 32'd64);
        wr(4'd4, 32'd0);
        pwm_run(3, 256, 32'd200);
        nchk++; if (hi_cnt[0] != 64) begin nerr++; $display("FAIL pend_p0 got %0d exp 64", hi_cnt[0]); end
        nchk++; if (hi_cnt[1] != 64) begin nerr++; $display("FAIL pend_p1 got %0d exp 64", hi_cnt[1]); end
        nchk++; if (hi_cnt[2] != 200) begin nerr++; $display("FAIL pend_p2 got %0d exp 200", hi_cnt[2]); end
    endtask

    task automatic test_invalid();
        logic [31:0] v;
        wr(4'd7, 32'hFFFF_FFFF);
        wr(4'd5, 32'hFFFF_FFFF);
        wr(4'd6, 32'hFFFF_FFFF);
        rd(4'd7, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL rd7 got %h exp 0", v); end
        rd(4'd0, v); nchk++; if (v !== 32'h7E) begin nerr++; $display("FAIL inv_data got %h exp 7e", v); end
        rd(4'd3, v); nchk++; if (v !== 32'h01) begin nerr++; $display("FAIL inv_mode got %h exp 1", v); end
        rd(4'd4, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL inv_presc got %h exp 0", v); end
        wr2(4'd14, 32'hFFFF_FFFF);
        wr2(4'd15, 32'hFFFF_FFFF);
        wr2(4'd7, 32'hFFFF_FFFF);
        wr2(4'd5, 32'hFFFF_FFFF);
        rd2(4'd14, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL ch6_rd got %h exp 0", v); end
        rd2(4'd15, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL ch7_rd got %h exp 0", v); end
        rd2(4'd7, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL rd7_6ch got %h exp 0", v); end
        rd2(4'd0, v); nchk++; if (v !== 32'h15) begin nerr++; $display("FAIL inv2_data got %h exp 15", v); end
        rd2(4'd13, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL inv2_duty5 got %h exp 0", v); end
        rd2(4'd8, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL inv2_duty0 got %h exp 0", v); end
        rd2(4'd3, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL inv2_mode got %h exp 0", v); end
        nchk++; if (out2 !== 6'h15) begin nerr++; $display("FAIL inv2_out got %h exp 15", out2); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        repeat (37) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        nchk++; if (out_port !== 8'hA5) begin nerr++; $display("FAIL midrst_out got %h exp a5", out_port); end
        rd(4'd6, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL midrst_cnt got %h exp 0", v); end
        rd(4'd3, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL midrst_mode got %h exp 0", v); end
        rd(4'd8, v); nchk++; if (v !== 32'd0) begin nerr++; $display("FAIL midrst_duty got %h exp 0", v); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        rd(4'd6, v); nchk++; if (v !== 32'd1) begin nerr++; $display("FAIL restart_cnt got %h exp 1", v); end
        nchk++; if (out_port !== 8'hA5) begin nerr++; $display("FAIL restart_out got %h exp a5", out_port); end
        repeat (4) @(posedge clk); #1;
        rd(4'd6, v); nchk++; if (v !== 32'd5) begin nerr++; $display("FAIL restart_cnt5 got %h exp 5", v); end
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; cs2 = 1'b0; write_n = 1'b1;
        address = 4'd0; writedata = 32'd0;
        test_reset();
        test_set_clr();
        test_pwm_basic();
        test_prescale();
        test_glitch_free();
        test_invalid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
